zeroriscy_wb_arbiter: RTL and testbench

Writeback arbiter sitting directly upstream of the flip-flop register file's single write port (W1). It merges the core's in-order writeback (ALU/LSU) with out-of-order results returning from the multi-cycle PPU, buffers PPU results in a small FIFO while the write port is busy, and reports which registers still have a buffered write pending so decode can stall on RAW/WAW hazards against the three read ports.

---
 rtl/zeroriscy_wb_pkg.sv | 21 ++
 rtl/zeroriscy_wb_fifo.sv | 83 ++++++++
 rtl/zeroriscy_wb_arbiter.sv | 115 +++++++++++
 tb/tb_zeroriscy_wb_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/zeroriscy_wb_pkg.sv
// Shared types and helpers for the zeroriscy writeback arbiter.
// Optional feature macro (used by the top): ZERORISCY_WB_BYPASS_EN.
package zeroriscy_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WB_DATA_W  = 32;

    // Default-width view of one buffered writeback; the FIFO declares a
    // local equivalent sized by its own DATA_WIDTH parameter.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0]  data;
    } wb_entry_t;

    // A read/dest port is hazarded only by a real register, never x0.
    function automatic logic addr_hit(input logic [REG_ADDR_W-1:0] a,
                                      input logic [REG_ADDR_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/zeroriscy_wb_fifo.sv
// PPU result buffer: circular storage with count, full/empty and a
// per-entry valid vector exposing buffered addresses for hazard checks.
module zeroriscy_wb_fifo
    import zeroriscy_wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_push,
    input  logic [REG_ADDR_W-1:0]                 i_push_addr,
    input  logic [DATA_WIDTH-1:0]                 i_push_data,
    input  logic                                  i_pop,
    output logic [REG_ADDR_W-1:0]                 o_head_addr,
    output logic [DATA_WIDTH-1:0]                 o_head_data,
    output logic                                  o_full,
    output logic                                  o_empty,
    output logic [FIFO_DEPTH-1:0]                 o_vld,
    output logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] o_addr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_count;
    logic [FIFO_DEPTH-1:0] r_vld;
    logic                  w_push;
    logic                  w_pop;

    assign o_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    assign o_head_addr = r_mem[r_rd_ptr].addr;
    assign o_head_data = r_mem[r_rd_ptr].data;
    assign o_vld       = r_vld;

    genvar g;
    generate
        for (g = 0; g < FIFO_DEPTH; g++) begin : g_addr
            assign o_addr[g] = r_mem[g].addr;
        end
    endgenerate

    // Entry storage is not reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= '{addr: i_push_addr, data: i_push_data};
    end

    // Pointers, occupancy and per-entry valid bits; reset drops everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
                r_vld[r_wr_ptr] <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
                r_vld[r_rd_ptr] <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/zeroriscy_wb_arbiter.sv
// Writeback arbiter for the register file write port: primary writeback
// always wins, PPU results are buffered and drained when the port is free.
// Define ZERORISCY_WB_BYPASS_EN to let a PPU result hit the port in the
// same cycle when nothing is buffered and the primary is idle.
module zeroriscy_wb_arbiter
    import zeroriscy_wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_we_i,
    input  logic [4:0]            wb_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    input  logic                  ppu_valid_i,
    output logic                  ppu_ready_o,
    input  logic [4:0]            ppu_addr_i,
    input  logic [DATA_WIDTH-1:0] ppu_data_i,
    output logic [4:0]            waddr_a_o,
    output logic [DATA_WIDTH-1:0] wdata_a_o,
    output logic                  we_a_o,
    input  logic [4:0]            raddr_a_i,
    input  logic [4:0]            raddr_b_i,
    input  logic [4:0]            raddr_c_i,
    input  logic [4:0]            dst_addr_i,
    output logic                  pend_a_o,
    output logic                  pend_b_o,
    output logic                  pend_c_o,
    output logic                  pend_dst_o,
    output logic                  fifo_empty_o
);

    logic                                  w_full;
    logic                                  w_empty;
    logic                                  w_accept;
    logic                                  w_push;
    logic                                  w_pop;
    logic                                  w_bypass;
    logic [REG_ADDR_W-1:0]                 w_head_addr;
    logic [DATA_WIDTH-1:0]                 w_head_data;
    logic [FIFO_DEPTH-1:0]                 w_vld;
    logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] w_addr;

    // Ready depends only on registered occupancy, never on a same-cycle drain.
    assign ppu_ready_o  = !w_full;
    assign fifo_empty_o = w_empty;
    assign w_accept     = ppu_valid_i && ppu_ready_o;

`ifdef ZERORISCY_WB_BYPASS_EN
    assign w_bypass = w_empty && !wb_we_i && ppu_valid_i && (ppu_addr_i != '0);
`else
    assign w_bypass = 1'b0;
`endif

    // Results to x0 are consumed but never stored; bypassed ones skip the FIFO.
    assign w_push = w_accept && (ppu_addr_i != '0) && !w_bypass;

    zeroriscy_wb_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_addr (ppu_addr_i),
        .i_push_data (ppu_data_i),
        .i_pop       (w_pop),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_vld       (w_vld),
        .o_addr      (w_addr)
    );

    // Write-port priority: primary, then FIFO head, then bypassed PPU result.
    always_comb begin
        we_a_o    = 1'b0;
        waddr_a_o = wb_addr_i;
        wdata_a_o = wb_data_i;
        w_pop     = 1'b0;
        if (rst) begin
            we_a_o = 1'b0;
        end else if (wb_we_i) begin
            we_a_o = 1'b1;
        end else if (!w_empty) begin
            we_a_o    = 1'b1;
            waddr_a_o = w_head_addr;
            wdata_a_o = w_head_data;
            w_pop     = 1'b1;
        end else if (w_bypass) begin
            we_a_o    = 1'b1;
            waddr_a_o = ppu_addr_i;
            wdata_a_o = ppu_data_i;
        end
    end

    // Hazard flags against buffered entries only (not this cycle's accept).
    always_comb begin
        pend_a_o   = 1'b0;
        pend_b_o   = 1'b0;
        pend_c_o   = 1'b0;
        pend_dst_o = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_vld[i]) begin
                pend_a_o   = pend_a_o   | addr_hit(raddr_a_i,  w_addr[i]);
                pend_b_o   = pend_b_o   | addr_hit(raddr_b_i,  w_addr[i]);
                pend_c_o   = pend_c_o   | addr_hit(raddr_c_i,  w_addr[i]);
                pend_dst_o = pend_dst_o | addr_hit(dst_addr_i, w_addr[i]);
            end
        end
    end

endmodule

// File: tb/tb_zeroriscy_wb_arbiter.sv
// Scoreboard bench for zeroriscy_wb_arbiter: a queue-based reference model
// predicts each cycle's register-file write; a monitor consumes them.
module tb_zeroriscy_wb_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wb_we_i = 1'b0;
    logic [4:0]    wb_addr_i = '0;
    logic [DW-1:0] wb_data_i = '0;
    logic          ppu_valid_i = 1'b0;
    logic          ppu_ready_o;
    logic [4:0]    ppu_addr_i = '0;
    logic [DW-1:0] ppu_data_i = '0;
    logic [4:0]    waddr_a_o;
    logic [DW-1:0] wdata_a_o;
    logic          we_a_o;
    logic [4:0]    raddr_a_i = '0, raddr_b_i = '0, raddr_c_i = '0, dst_addr_i = '0;
    logic          pend_a_o, pend_b_o, pend_c_o, pend_dst_o;
    logic          fifo_empty_o;

    always #5 clk = ~clk;

    zeroriscy_wb_arbiter #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .ppu_valid_i(ppu_valid_i), .ppu_ready_o(ppu_ready_o),
        .ppu_addr_i(ppu_addr_i), .ppu_data_i(ppu_data_i),
        .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o), .we_a_o(we_a_o),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .raddr_c_i(raddr_c_i),
        .dst_addr_i(dst_addr_i),
        .pend_a_o(pend_a_o), .pend_b_o(pend_b_o), .pend_c_o(pend_c_o),
        .pend_dst_o(pend_dst_o), .fifo_empty_o(fifo_empty_o)
    );

    typedef struct {
        logic [4:0]    addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t fq[$];     // model of buffered PPU results, oldest first
    wr_t exp_q[$];  // expected register-file writes
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic mpend(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (fq[i]) if (fq[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    // One clock of stimulus; checks flags and predicts this cycle's write.
    task automatic cyc(input logic r, input logic we, input logic [4:0] wa, input logic [DW-1:0] wd,
                       input logic pv, input logic [4:0] pa, input logic [DW-1:0] pd, output logic acc);
        logic byp;
        logic exp_we;
        @(negedge clk);
        rst = r; wb_we_i = we; wb_addr_i = wa; wb_data_i = wd;
        ppu_valid_i = pv; ppu_addr_i = pa; ppu_data_i = pd;
        raddr_a_i  = 5'($urandom_range(0, 7));
        raddr_b_i  = 5'($urandom_range(0, 7));
        raddr_c_i  = 5'($urandom_range(0, 7));
        dst_addr_i = 5'($urandom_range(0, 7));
        #1;
        acc = 1'b0;
        if (r) begin
            chk("we_during_rst", we_a_o, 0);
            fq.delete();
        end else begin
            chk("ppu_ready", ppu_ready_o, fq.size() < DEPTH);
            chk("fifo_empty", fifo_empty_o, fq.size() == 0);
            chk("pend_a", pend_a_o, mpend(raddr_a_i));
            chk("pend_b", pend_b_o, mpend(raddr_b_i));
            chk("pend_c", pend_c_o, mpend(raddr_c_i));
            chk("pend_dst", pend_dst_o, mpend(dst_addr_i));
            acc = pv && (fq.size() < DEPTH);
            byp = 1'b0;
`ifdef ZERORISCY_WB_BYPASS_EN
            byp = acc && (fq.size() == 0) && !we && (pa != 5'd0);
`endif
            exp_we = 1'b1;
            if (we)                exp_q.push_back('{wa, wd});
            else if (fq.size() > 0) exp_q.push_back(fq.pop_front());
            else if (byp)          exp_q.push_back('{pa, pd});
            else                   exp_we = 1'b0;
            chk("we_a", we_a_o, exp_we);
            if (acc && pa != 5'd0 && !byp) fq.push_back('{pa, pd});
        end
    endtask

    // Monitor: every observed write must be the next predicted one.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && we_a_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got x%0d=%h want no write", waddr_a_o, wdata_a_o);
                end else begin
                    w = exp_q.pop_front();
                    chk("waddr", waddr_a_o, w.addr);
                    chk("wdata", wdata_a_o, w.data);
                end
            end
            if (!rst) chk("write_missing", exp_q.size(), 0);
        end
    end

    initial begin
        logic acc;
        int   idx;
        // reset then idle
        cyc(1, 0, 0, 0, 0, 0, 0, acc);
        cyc(1, 1, 3, 32'h1, 1, 4, 32'h2, acc);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, acc);
        // single PPU result to x5
        cyc(0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF, acc);
        chk("single_acc", acc, 1);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, acc);
        // primary busy 6 cycles while 5 PPU results are offered
        idx = 1;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 5'(20 + i), 32'hA000 + i, idx <= 5, 5'(idx), 32'h1000 + idx, acc);
            if (acc) idx++;
        end
        chk("burst_accepted_4", idx, 5);
        for (int k = 0; k < 50 && idx <= 5; k++) begin
            cyc(0, 0, 0, 0, 1, 5'(idx), 32'h1000 + idx, acc);
            if (acc) idx++;
        end
        chk("burst_done", idx, 6);
        repeat (6) cyc(0, 0, 0, 0, 0, 0, 0, acc);
        // fill to 2 then simultaneous push/pop across the pointer wrap
        for (int i = 0; i < 2; i++) cyc(0, 1, 5'd9, 32'hB0 + i, 1, 5'(1 + i), 32'hC0 + i, acc);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1, 5'(3 + i), 32'hD0 + i, acc);
        repeat (4) cyc(0, 0, 0, 0, 0, 0, 0, acc);
        // PPU result to x0 is swallowed
        cyc(0, 0, 0, 0, 1, 5'd0, 32'h5555, acc);
        chk("x0_acc", acc, 1);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, acc);
        // reset with 3 buffered entries
        for (int i = 0; i < 3; i++) cyc(0, 1, 5'd8, 32'hE0 + i, 1, 5'(2 + i), 32'hF0 + i, acc);
        cyc(1, 0, 0, 0, 0, 0, 0, acc);
        repeat (4) cyc(0, 0, 0, 0, 0, 0, 0, acc);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 99) < 45),
                5'($urandom), $urandom, ($urandom_range(0, 99) < 60),
                5'($urandom_range(0, 7)), $urandom, acc);
        end
        repeat (8) cyc(0, 0, 0, 0, 0, 0, 0, acc);
        chk("model_drained", fq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
